// File: rtl/ball_mover_gen2.sv
// Ball position controller: scans the ball's leading edge against an external map port
// and commits 1-pixel steps per axis. Optional request rate limit: BALL_RATE_LIMIT_EN.
module ball_mover_gen2 #(
  parameter int                    X_WIDTH      = 10,
  parameter int                    Y_WIDTH      = 9,
  parameter int                    PX_WIDTH     = 8,
  parameter int                    INITIAL_X    = 527,
  parameter int                    INITIAL_Y    = 254,
  parameter int                    RADIUS       = 8,
  parameter logic [PX_WIDTH-1:0]   VALID_PX     = 8'h26,
  parameter logic [PX_WIDTH-1:0]   GOAL_PX      = 8'h1C,
  parameter int                    READ_LATENCY = 3,
  parameter int                    RATE_DIV     = 3333333
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          movement,
  output logic [X_WIDTH-1:0]  map_col_addr,
  output logic [Y_WIDTH-1:0]  map_row_addr,
  input  logic [PX_WIDTH-1:0] map_px,
  output logic [X_WIDTH-1:0]  x_out,
  output logic [Y_WIDTH-1:0]  y_out,
  output logic                busy,
  output logic                moved,
  output logic                blocked,
  output logic                goal_hit
);

  localparam int SPAN = 2*RADIUS-1;
  localparam int IW   = $clog2(SPAN+1);
  localparam int WCW  = $clog2(READ_LATENCY+1);

  typedef enum logic [2:0] {IDLE, ADDR, WAIT, CHECK, COMMIT} state_t;
  state_t state, state_n;

  logic               vert, vert_n, h_pos, h_pos_n, v_pos, v_pos_n, v_pend, v_pend_n;
  logic [IW-1:0]      idx, idx_n;
  logic [WCW-1:0]     wcnt;
  logic [X_WIDTH-1:0] x_n, pix_col;
  logic [Y_WIDTH-1:0] y_n, pix_row;
  logic               goal_flag;
  logic               h_req, v_req, tick, accept, bnd_blk, px_bad, px_last, axis_done, ld_addr;

  // Edge of the ball would leave the screen; arithmetic widened by one bit so it cannot wrap.
  function automatic logic oob(input logic vrt, input logic pos,
                               input logic [X_WIDTH-1:0] x, input logic [Y_WIDTH-1:0] y);
    logic r;
    if (!vrt)
      r = pos ? (({1'b0, x} + (X_WIDTH+1)'(RADIUS)) > {1'b0, {X_WIDTH{1'b1}}})
              : ({1'b0, x} < (X_WIDTH+1)'(RADIUS));
    else
      r = pos ? (({1'b0, y} + (Y_WIDTH+1)'(RADIUS)) > {1'b0, {Y_WIDTH{1'b1}}})
              : ({1'b0, y} < (Y_WIDTH+1)'(RADIUS));
    return r;
  endfunction

`ifdef BALL_RATE_LIMIT_EN
  localparam int RCW = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;
  logic [RCW-1:0] rate_cnt;
  assign tick = (rate_cnt == RCW'(RATE_DIV-1));
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     rate_cnt <= '0;
    else if (tick) rate_cnt <= '0;
    else           rate_cnt <= rate_cnt + RCW'(1);
  end
`else
  assign tick = 1'b1;
`endif

  // Opposite directions on one axis cancel
  assign h_req     = movement[2] ^ movement[3];
  assign v_req     = movement[0] ^ movement[1];
  assign accept    = (state == IDLE) && (h_req || v_req) && tick;
  assign bnd_blk   = (state == ADDR) && (idx == '0) && oob(vert, vert ? v_pos : h_pos, x_out, y_out);
  assign px_bad    = (state == CHECK) && (map_px != VALID_PX) && (map_px != GOAL_PX);
  assign px_last   = (idx == IW'(SPAN-1));
  assign axis_done = bnd_blk || px_bad || (state == COMMIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = ADDR;
      ADDR:    if (bnd_blk) state_n = v_pend ? ADDR : IDLE;
               else         state_n = (READ_LATENCY == 1) ? CHECK : WAIT;
      WAIT:    if (wcnt == WCW'(READ_LATENCY-1)) state_n = CHECK;
      CHECK:   if (px_bad)       state_n = v_pend ? ADDR : IDLE;
               else if (px_last) state_n = COMMIT;
               else              state_n = ADDR;
      COMMIT:  state_n = v_pend ? ADDR : IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  // Next datapath values; the map address is loaded on entry to ADDR so it is
  // already on the port during the ADDR cycle.
  always_comb begin
    vert_n   = vert;
    h_pos_n  = h_pos;
    v_pos_n  = v_pos;
    v_pend_n = v_pend;
    idx_n    = idx;
    x_n      = x_out;
    y_n      = y_out;
    case (state)
      IDLE: if (accept) begin
        vert_n   = !h_req;
        h_pos_n  = movement[3];
        v_pos_n  = movement[1];
        v_pend_n = h_req && v_req;
        idx_n    = '0;
      end
      CHECK: if (!px_bad && !px_last) idx_n = idx + IW'(1);
      COMMIT: begin
        if (!vert) x_n = h_pos ? x_out + X_WIDTH'(1) : x_out - X_WIDTH'(1);
        else       y_n = v_pos ? y_out + Y_WIDTH'(1) : y_out - Y_WIDTH'(1);
      end
      default: ;
    endcase
    if (axis_done) begin
      idx_n = '0;
      if (v_pend) begin
        vert_n   = 1'b1;
        v_pend_n = 1'b0;
      end
    end
    if (!vert_n) begin
      pix_col = h_pos_n ? x_n + X_WIDTH'(RADIUS) : x_n - X_WIDTH'(RADIUS);
      pix_row = y_n - Y_WIDTH'(RADIUS-1) + Y_WIDTH'(idx_n);
    end else begin
      pix_row = v_pos_n ? y_n + Y_WIDTH'(RADIUS) : y_n - Y_WIDTH'(RADIUS);
      pix_col = x_n - X_WIDTH'(RADIUS-1) + X_WIDTH'(idx_n);
    end
    // An out-of-bounds first pixel is never put on the map port
    ld_addr = (state_n == ADDR) &&
              !((idx_n == '0) && oob(vert_n, vert_n ? v_pos_n : h_pos_n, x_n, y_n));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vert         <= 1'b0;
      h_pos        <= 1'b0;
      v_pos        <= 1'b0;
      v_pend       <= 1'b0;
      idx          <= '0;
      wcnt         <= '0;
      x_out        <= X_WIDTH'(INITIAL_X);
      y_out        <= Y_WIDTH'(INITIAL_Y);
      map_col_addr <= '0;
      map_row_addr <= '0;
      moved        <= 1'b0;
      blocked      <= 1'b0;
      goal_flag    <= 1'b0;
      goal_hit     <= 1'b0;
    end else begin
      vert    <= vert_n;
      h_pos   <= h_pos_n;
      v_pos   <= v_pos_n;
      v_pend  <= v_pend_n;
      idx     <= idx_n;
      x_out   <= x_n;
      y_out   <= y_n;
      wcnt    <= (state == ADDR) ? WCW'(1) : (state == WAIT) ? wcnt + WCW'(1) : '0;
      moved   <= (state == COMMIT);
      blocked <= bnd_blk || px_bad;
      if (ld_addr) begin
        map_col_addr <= pix_col;
        map_row_addr <= pix_row;
      end
      if (axis_done)                                goal_flag <= 1'b0;
      else if (state == CHECK && map_px == GOAL_PX) goal_flag <= 1'b1;
      if (state == COMMIT && goal_flag) goal_hit <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ball_mover_gen2.sv
// Directed bench for ball_mover_gen2: vector table of single requests plus
// sequences for latency, mid-scan reset, sticky goal and screen bounds.
module tb_ball_mover_gen2;
  localparam int RL = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] movement;
  logic [9:0] map_col_addr, x_out;
  logic [8:0] map_row_addr, y_out;
  logic [7:0] map_px;
  logic       busy, moved, blocked, goal_hit;

  ball_mover_gen2 dut (
    .clk(clk), .reset(reset), .movement(movement),
    .map_col_addr(map_col_addr), .map_row_addr(map_row_addr), .map_px(map_px),
    .x_out(x_out), .y_out(y_out), .busy(busy), .moved(moved),
    .blocked(blocked), .goal_hit(goal_hit)
  );

  always #5 clk = ~clk;

  // Map model: open floor with one optional wall pixel and one optional goal pixel
  logic       bad_en, goal_en;
  logic [9:0] bad_c, goal_c;
  logic [8:0] bad_r, goal_r;
  logic [7:0] pipe [RL];

  function automatic logic [7:0] map_at(input logic [9:0] c, input logic [8:0] r);
    if (bad_en && c == bad_c && r == bad_r)    return 8'h00;
    if (goal_en && c == goal_c && r == goal_r) return 8'h1C;
    return 8'h26;
  endfunction

  always @(posedge clk) begin
    pipe[0] <= map_at(map_col_addr, map_row_addr);
    for (int k = 1; k < RL; k++) pipe[k] <= pipe[k-1];
  end
  assign map_px = pipe[RL-1];

  // Monitor: a read is any change of the map address
  int          cyc = 0, reads = 0, n_moved = 0, n_blocked = 0, first_rd = 0;
  int          mv_cyc [4];
  logic [9:0]  rd_c [64];
  logic [8:0]  rd_r [64];
  logic [18:0] prev_a = '0;

  always @(posedge clk) begin
    #2;
    cyc++;
    if (!reset) begin
      if ({map_col_addr, map_row_addr} != prev_a) begin
        if (reads == 0) first_rd = cyc;
        if (reads < 64) begin
          rd_c[reads] = map_col_addr;
          rd_r[reads] = map_row_addr;
        end
        reads++;
      end
      if (moved) begin
        if (n_moved < 4) mv_cyc[n_moved] = cyc;
        n_moved++;
      end
      if (blocked) n_blocked++;
    end
    prev_a = {map_col_addr, map_row_addr};
  end

  int total = 0, bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_counts();
    reads = 0; n_moved = 0; n_blocked = 0; first_rd = 0;
    for (int k = 0; k < 4; k++) mv_cyc[k] = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1; movement = 4'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    clear_counts();
  endtask

  task automatic pulse(input logic [3:0] m);
    @(negedge clk); movement = m;
    @(negedge clk); movement = 4'b0;
  endtask

  task automatic set_map(input logic be, input logic [9:0] bc, input logic [8:0] br,
                         input logic ge, input logic [9:0] gc, input logic [8:0] gr);
    bad_en = be; bad_c = bc; bad_r = br; goal_en = ge; goal_c = gc; goal_r = gr;
  endtask

  typedef struct {
    logic [3:0] mv;
    logic       be; logic [9:0] bc; logic [8:0] br;
    logic       ge; logic [9:0] gc; logic [8:0] gr;
    int         ex, ey, emv, ebl, erd;
    logic       eg;
  } vec_t;

  vec_t vt [15];

  initial begin
    int n, errs;
    reset = 1'b1; movement = 4'b0;
    set_map(0, 0, 0, 0, 0, 0);
    //         mv       bad             goal            x    y   mv bl rd  goal
    vt[0]  = '{4'b1000, 0, 0,   0,   0, 0,   0,   528, 254, 1, 0, 15, 0};
    vt[1]  = '{4'b0100, 0, 0,   0,   0, 0,   0,   526, 254, 1, 0, 15, 0};
    vt[2]  = '{4'b0001, 0, 0,   0,   0, 0,   0,   527, 253, 1, 0, 15, 0};
    vt[3]  = '{4'b0010, 0, 0,   0,   0, 0,   0,   527, 255, 1, 0, 15, 0};
    vt[4]  = '{4'b1001, 0, 0,   0,   0, 0,   0,   528, 253, 2, 0, 30, 0};
    vt[5]  = '{4'b1100, 0, 0,   0,   0, 0,   0,   527, 254, 0, 0,  0, 0};
    vt[6]  = '{4'b0011, 0, 0,   0,   0, 0,   0,   527, 254, 0, 0,  0, 0};
    vt[7]  = '{4'b1111, 0, 0,   0,   0, 0,   0,   527, 254, 0, 0,  0, 0};
    vt[8]  = '{4'b1000, 1, 535, 254, 0, 0,   0,   527, 254, 0, 1,  8, 0};
    vt[9]  = '{4'b1000, 0, 0,   0,   1, 535, 250, 528, 254, 1, 0, 15, 1};
    vt[10] = '{4'b1010, 1, 535, 254, 0, 0,   0,   527, 255, 1, 1, 23, 0};
    vt[11] = '{4'b0100, 1, 519, 247, 0, 0,   0,   527, 254, 0, 1,  1, 0};
    vt[12] = '{4'b0101, 0, 0,   0,   1, 519, 261, 526, 253, 2, 0, 30, 1};
    vt[13] = '{4'b0010, 1, 534, 262, 0, 0,   0,   527, 254, 0, 1, 15, 0};
    vt[14] = '{4'b0111, 0, 0,   0,   0, 0,   0,   526, 254, 1, 0, 15, 0};

    // Reset state
    do_reset();
    chk("rst_x", x_out, 527);
    chk("rst_y", y_out, 254);
    chk("rst_busy", busy, 0);
    chk("rst_goal", goal_hit, 0);
    chk("rst_col", map_col_addr, 0);

    for (int i = 0; i < 15; i++) begin
      do_reset();
      set_map(vt[i].be, vt[i].bc, vt[i].br, vt[i].ge, vt[i].gc, vt[i].gr);
      pulse(vt[i].mv);
      repeat (140) @(negedge clk);
      chk($sformatf("v%0d_x", i), x_out, vt[i].ex);
      chk($sformatf("v%0d_y", i), y_out, vt[i].ey);
      chk($sformatf("v%0d_moved", i), n_moved, vt[i].emv);
      chk($sformatf("v%0d_blocked", i), n_blocked, vt[i].ebl);
      chk($sformatf("v%0d_reads", i), reads, vt[i].erd);
      chk($sformatf("v%0d_goal", i), goal_hit, vt[i].eg);
    end

    // Single-axis latency and scanned addresses
    do_reset();
    set_map(0, 0, 0, 0, 0, 0);
    pulse(4'b1000);
    repeat (4) @(negedge clk);
    chk("scan_busy", busy, 1);
    repeat (80) @(negedge clk);
    chk("lat_right", mv_cyc[0] - first_rd, 61);
    chk("rd0_col", rd_c[0], 535);
    chk("rd0_row", rd_r[0], 247);
    chk("rd14_row", rd_r[14], 261);
    errs = 0;
    for (int k = 0; k < 15; k++)
      if (rd_c[k] !== 10'd535 || rd_r[k] !== 9'(247 + k)) errs++;
    chk("scan_addrs", errs, 0);
    chk("idle_busy", busy, 0);

    // Diagonal: X step then Y step using the new x
    do_reset();
    pulse(4'b1001);
    repeat (150) @(negedge clk);
    chk("diag_lat", mv_cyc[1] - mv_cyc[0], 61);
    chk("diag_vcol", rd_c[15], 521);
    chk("diag_vrow", rd_r[15], 246);

    // Reset in the middle of a scan
    do_reset();
    pulse(4'b1000);
    repeat (20) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mrst_x", x_out, 527);
    chk("mrst_y", y_out, 254);
    chk("mrst_busy", busy, 0);
    chk("mrst_row", map_row_addr, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    clear_counts();
    repeat (100) @(negedge clk);
    chk("mrst_moved", n_moved, 0);
    chk("mrst_blocked", n_blocked, 0);
    chk("mrst_reads", reads, 0);

    // goal_hit is sticky
    do_reset();
    set_map(0, 0, 0, 1, 535, 250);
    pulse(4'b1000);
    repeat (80) @(negedge clk);
    chk("goal_set", goal_hit, 1);
    pulse(4'b1000);
    repeat (80) @(negedge clk);
    pulse(4'b0100);
    repeat (80) @(negedge clk);
    chk("goal_hold", goal_hit, 1);
    chk("goal_x", x_out, 528);

    // Right screen bound
    do_reset();
    set_map(0, 0, 0, 0, 0, 0);
    @(negedge clk); movement = 4'b1000;
    n = 0;
    while (x_out != 10'd1016 && n < 40000) begin @(negedge clk); n++; end
    movement = 4'b0;
    chk("reach_xmax", x_out, 1016);
    repeat (80) @(negedge clk);
    clear_counts();
    pulse(4'b1000);
    repeat (20) @(negedge clk);
    chk("xb_blocked", n_blocked, 1);
    chk("xb_reads", reads, 0);
    chk("xb_x", x_out, 1016);
    pulse(4'b0100);
    repeat (80) @(negedge clk);
    chk("xb_left", x_out, 1015);

    // Top screen bound
    @(negedge clk); movement = 4'b0001;
    n = 0;
    while (y_out != 9'd7 && n < 20000) begin @(negedge clk); n++; end
    movement = 4'b0;
    chk("reach_ymin", y_out, 7);
    repeat (80) @(negedge clk);
    clear_counts();
    pulse(4'b0001);
    repeat (20) @(negedge clk);
    chk("yb_blocked", n_blocked, 1);
    chk("yb_reads", reads, 0);
    chk("yb_y", y_out, 7);
    chk("yb_moved", n_moved, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
